// File: rtl/mips_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_pkg
// Description : Shared opcodes, CP0 numbering, exception codes and reset
//               vectors for the single-cycle MIPS core.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_cpu_pkg;

    localparam logic [31:0] c_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] c_HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] c_PC_MIN     = 32'h0000_3000;
    localparam logic [31:0] c_PC_MAX     = 32'h0000_6FFC;

    localparam logic [5:0] c_OP_SPECIAL = 6'b000000;
    localparam logic [5:0] c_OP_J       = 6'b000010;
    localparam logic [5:0] c_OP_JAL     = 6'b000011;
    localparam logic [5:0] c_OP_BEQ     = 6'b000100;
    localparam logic [5:0] c_OP_BNE     = 6'b000101;
    localparam logic [5:0] c_OP_ADDI    = 6'b001000;
    localparam logic [5:0] c_OP_ADDIU   = 6'b001001;
    localparam logic [5:0] c_OP_ANDI    = 6'b001100;
    localparam logic [5:0] c_OP_ORI     = 6'b001101;
    localparam logic [5:0] c_OP_LUI     = 6'b001111;
    localparam logic [5:0] c_OP_COP0    = 6'b010000;
    localparam logic [5:0] c_OP_LB      = 6'b100000;
    localparam logic [5:0] c_OP_LH      = 6'b100001;
    localparam logic [5:0] c_OP_LW      = 6'b100011;
    localparam logic [5:0] c_OP_SB      = 6'b101000;
    localparam logic [5:0] c_OP_SH      = 6'b101001;
    localparam logic [5:0] c_OP_SW      = 6'b101011;

    localparam logic [5:0] c_FN_JR   = 6'b001000;
    localparam logic [5:0] c_FN_ADD  = 6'b100000;
    localparam logic [5:0] c_FN_SUB  = 6'b100010;
    localparam logic [5:0] c_FN_AND  = 6'b100100;
    localparam logic [5:0] c_FN_OR   = 6'b100101;
    localparam logic [5:0] c_FN_SLT  = 6'b101010;
    localparam logic [5:0] c_FN_SLTU = 6'b101011;
    localparam logic [5:0] c_FN_ERET = 6'b011000;

    // COP0 sub-operation lives in the rs field
    localparam logic [4:0] c_COP0_MF   = 5'b00000;
    localparam logic [4:0] c_COP0_MT   = 5'b00100;
    localparam logic [4:0] c_COP0_ERET = 5'b10000;

    localparam logic [4:0] c_CP0_SR    = 5'd12;
    localparam logic [4:0] c_CP0_CAUSE = 5'd13;
    localparam logic [4:0] c_CP0_EPC   = 5'd14;

    localparam logic [4:0] c_EXC_INT  = 5'd0;
    localparam logic [4:0] c_EXC_ADEL = 5'd4;
    localparam logic [4:0] c_EXC_ADES = 5'd5;
    localparam logic [4:0] c_EXC_RI   = 5'd10;
    localparam logic [4:0] c_EXC_OV   = 5'd12;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLTU, ALU_LUI
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU, WB_MEM, WB_PC8, WB_CP0
    } wb_sel_e;

    typedef enum logic [1:0] {
        SZ_WORD, SZ_HALF, SZ_BYTE
    } mem_size_e;

endpackage
`default_nettype wire

// File: rtl/mips_cpu_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_if
// Description : Instruction fetch, data memory and write-back trace bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_cpu_if;
    logic [31:0] macroscopic_pc;
    logic [31:0] i_inst_addr;
    logic [31:0] i_inst_rdata;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_rdata;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr;
    logic        w_grf_we;
    logic [4:0]  w_grf_addr;
    logic [31:0] w_grf_wdata;
    logic [31:0] w_inst_addr;

    modport master (
        output macroscopic_pc, i_inst_addr, m_data_addr, m_data_wdata,
               m_data_byteen, m_inst_addr, w_grf_we, w_grf_addr,
               w_grf_wdata, w_inst_addr,
        input  i_inst_rdata, m_data_rdata
    );

    modport slave (
        input  macroscopic_pc, i_inst_addr, m_data_addr, m_data_wdata,
               m_data_byteen, m_inst_addr, w_grf_we, w_grf_addr,
               w_grf_wdata, w_inst_addr,
        output i_inst_rdata, m_data_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mips_cpu_cp0.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_cp0
// Description : SR/Cause/EPC, interrupt request and exception entry/exit.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_cp0
    import mips_cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_interrupt,
    input  logic [31:0] i_pc,
    input  logic        i_in_delay_slot,
    input  logic        i_exc_valid,
    input  logic [4:0]  i_exc_code,
    input  logic        i_mtc0,
    input  logic [4:0]  i_cp0_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_eret,
    output logic [31:0] o_rdata,
    output logic [31:0] o_epc,
    output logic        o_take
);

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [4:0]  r_exc_code;
    logic [31:0] r_epc;

    logic [5:0]  w_hwint;
    logic        w_irq;
    logic [31:0] w_sr;
    logic [31:0] w_cause;

    // External request is HWInt[2], i.e. IM/IP bit 12
    assign w_hwint = {3'b000, i_interrupt, 2'b00};
    assign w_irq   = i_interrupt & r_im[2] & r_ie & ~r_exl;
    assign o_take  = w_irq | i_exc_valid;

    assign w_sr    = {16'h0000, r_im, 8'h00, r_exl, r_ie};
    assign w_cause = {r_bd, 15'h0000, w_hwint, 3'b000, r_exc_code, 2'b00};
    assign o_epc   = r_epc;

    always_comb begin
        o_rdata = '0;
        case (i_cp0_addr)
            c_CP0_SR:    o_rdata = w_sr;
            c_CP0_CAUSE: o_rdata = w_cause;
            c_CP0_EPC:   o_rdata = r_epc;
            default:     o_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_im       <= '0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_exc_code <= '0;
            r_epc      <= '0;
        end else if (o_take) begin
            // Entry wins over any mtc0/eret of the squashed instruction
            r_exl      <= 1'b1;
            r_exc_code <= w_irq ? c_EXC_INT : i_exc_code;
            r_bd       <= i_in_delay_slot;
            r_epc      <= i_in_delay_slot ? (i_pc - 32'd4) : i_pc;
        end else begin
            if (i_eret) begin
                r_exl <= 1'b0;
            end
            if (i_mtc0 && i_cp0_addr == c_CP0_SR) begin
                r_im  <= i_wdata[15:10];
                r_exl <= i_wdata[1];
                r_ie  <= i_wdata[0];
            end
            if (i_mtc0 && i_cp0_addr == c_CP0_EPC) begin
                r_epc <= i_wdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_cpu.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu
// Description : Single-cycle MIPS core with delay slot, GRF, ALU and CP0.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu
    import mips_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = c_RESET_PC,
    parameter logic [31:0] HANDLER_PC = c_HANDLER_PC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       interrupt,
    mips_cpu_if.master bus
);

    logic [31:0] r_pc, r_npc;
    logic        r_in_ds;
    logic [31:0] r_grf [32];

    logic [31:0] w_inst;
    logic [5:0]  w_op, w_fn;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [31:0] w_rs_val, w_rt_val, w_imm_sext, w_imm_ext, w_alu_b;
    logic [31:0] w_alu_res, w_maddr, w_load_val, w_st_data, w_wb_data;
    logic [31:0] w_cp0_rdata, w_epc, w_pc_plus4, w_br_target, w_j_target;
    logic [32:0] w_add33, w_sub33;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [3:0]  w_be;
    logic [4:0]  w_dst, w_exc_code;
    logic        w_reg_write, w_imm_zext, w_alu_b_imm, w_ovf_chk, w_ri;
    logic        w_load, w_store, w_beq, w_bne, w_jump, w_jr, w_cti;
    logic        w_mtc0, w_eret, w_ov, w_misalign, w_pc_bad;
    logic        w_exc_valid, w_take, w_we, w_br_taken;
    alu_op_e     w_alu_op;
    wb_sel_e     w_wb_sel;
    mem_size_e   w_size;

    assign w_inst     = bus.i_inst_rdata;
    assign w_op       = w_inst[31:26];
    assign w_rs       = w_inst[25:21];
    assign w_rt       = w_inst[20:16];
    assign w_rd       = w_inst[15:11];
    assign w_fn       = w_inst[5:0];
    assign w_imm_sext = {{16{w_inst[15]}}, w_inst[15:0]};
    assign w_imm_ext  = w_imm_zext ? {16'h0000, w_inst[15:0]} : w_imm_sext;
    assign w_rs_val   = r_grf[w_rs];
    assign w_rt_val   = r_grf[w_rt];

    always_comb begin
        w_alu_op    = ALU_ADD;
        w_alu_b_imm = 1'b0;
        w_imm_zext  = 1'b0;
        w_reg_write = 1'b0;
        w_dst       = w_rd;
        w_wb_sel    = WB_ALU;
        w_size      = SZ_WORD;
        w_ovf_chk   = 1'b0;
        w_load      = 1'b0;
        w_store     = 1'b0;
        w_beq       = 1'b0;
        w_bne       = 1'b0;
        w_jump      = 1'b0;
        w_jr        = 1'b0;
        w_mtc0      = 1'b0;
        w_eret      = 1'b0;
        w_ri        = 1'b0;
        case (w_op)
            c_OP_SPECIAL: begin
                w_reg_write = 1'b1;
                case (w_fn)
                    c_FN_ADD:  begin w_alu_op = ALU_ADD; w_ovf_chk = 1'b1; end
                    c_FN_SUB:  begin w_alu_op = ALU_SUB; w_ovf_chk = 1'b1; end
                    c_FN_AND:  w_alu_op = ALU_AND;
                    c_FN_OR:   w_alu_op = ALU_OR;
                    c_FN_SLT:  w_alu_op = ALU_SLT;
                    c_FN_SLTU: w_alu_op = ALU_SLTU;
                    c_FN_JR:   begin w_jr = 1'b1; w_reg_write = 1'b0; end
                    default:   begin w_ri = 1'b1; w_reg_write = 1'b0; end
                endcase
            end
            c_OP_ADDI, c_OP_ADDIU, c_OP_ANDI, c_OP_ORI, c_OP_LUI: begin
                w_reg_write = 1'b1;
                w_dst       = w_rt;
                w_alu_b_imm = 1'b1;
                w_ovf_chk   = (w_op == c_OP_ADDI);
                w_imm_zext  = (w_op == c_OP_ANDI) || (w_op == c_OP_ORI);
                if (w_op == c_OP_ANDI)     w_alu_op = ALU_AND;
                else if (w_op == c_OP_ORI) w_alu_op = ALU_OR;
                else if (w_op == c_OP_LUI) w_alu_op = ALU_LUI;
            end
            c_OP_LW, c_OP_LH, c_OP_LB: begin
                w_load      = 1'b1;
                w_reg_write = 1'b1;
                w_dst       = w_rt;
                w_wb_sel    = WB_MEM;
                w_size      = (w_op == c_OP_LW) ? SZ_WORD : (w_op == c_OP_LH) ? SZ_HALF : SZ_BYTE;
            end
            c_OP_SW, c_OP_SH, c_OP_SB: begin
                w_store = 1'b1;
                w_size  = (w_op == c_OP_SW) ? SZ_WORD : (w_op == c_OP_SH) ? SZ_HALF : SZ_BYTE;
            end
            c_OP_BEQ: w_beq = 1'b1;
            c_OP_BNE: w_bne = 1'b1;
            c_OP_J:   w_jump = 1'b1;
            c_OP_JAL: begin
                w_jump      = 1'b1;
                w_reg_write = 1'b1;
                w_dst       = 5'd31;
                w_wb_sel    = WB_PC8;
            end
            c_OP_COP0: begin
                case (w_rs)
                    c_COP0_MF: begin
                        w_reg_write = 1'b1;
                        w_dst       = w_rt;
                        w_wb_sel    = WB_CP0;
                    end
                    c_COP0_MT:   w_mtc0 = 1'b1;
                    c_COP0_ERET: if (w_fn == c_FN_ERET) w_eret = 1'b1; else w_ri = 1'b1;
                    default:     w_ri = 1'b1;
                endcase
            end
            default: w_ri = 1'b1;
        endcase
    end

    assign w_cti   = w_beq | w_bne | w_jump | w_jr;
    assign w_alu_b = w_alu_b_imm ? w_imm_ext : w_rt_val;
    assign w_add33 = {w_rs_val[31], w_rs_val} + {w_alu_b[31], w_alu_b};
    assign w_sub33 = {w_rs_val[31], w_rs_val} - {w_alu_b[31], w_alu_b};
    assign w_ov    = w_ovf_chk && ((w_alu_op == ALU_SUB) ? (w_sub33[32] ^ w_sub33[31])
                                                         : (w_add33[32] ^ w_add33[31]));

    always_comb begin
        w_alu_res = w_add33[31:0];
        case (w_alu_op)
            ALU_SUB:  w_alu_res = w_sub33[31:0];
            ALU_AND:  w_alu_res = w_rs_val & w_alu_b;
            ALU_OR:   w_alu_res = w_rs_val | w_alu_b;
            ALU_SLT:  w_alu_res = {31'd0, $signed(w_rs_val) < $signed(w_alu_b)};
            ALU_SLTU: w_alu_res = {31'd0, w_rs_val < w_alu_b};
            ALU_LUI:  w_alu_res = {w_inst[15:0], 16'h0000};
            default:  w_alu_res = w_add33[31:0];
        endcase
    end

    // Memory access: lane selection for loads, byte enables for stores
    assign w_maddr = w_rs_val + w_imm_sext;
    assign w_half  = w_maddr[1] ? bus.m_data_rdata[31:16] : bus.m_data_rdata[15:0];
    assign w_byte  = bus.m_data_rdata[8*w_maddr[1:0] +: 8];

    always_comb begin
        w_load_val = bus.m_data_rdata;
        w_be       = 4'b1111;
        w_st_data  = w_rt_val;
        case (w_size)
            SZ_HALF: begin
                w_load_val = {{16{w_half[15]}}, w_half};
                w_be       = w_maddr[1] ? 4'b1100 : 4'b0011;
                w_st_data  = {2{w_rt_val[15:0]}};
            end
            SZ_BYTE: begin
                w_load_val = {{24{w_byte[7]}}, w_byte};
                w_be       = 4'b0001 << w_maddr[1:0];
                w_st_data  = {4{w_rt_val[7:0]}};
            end
            default: ;
        endcase
    end

    assign w_misalign = (w_size == SZ_WORD && w_maddr[1:0] != 2'b00) ||
                        (w_size == SZ_HALF && w_maddr[0]);
    assign w_pc_bad   = (r_pc[1:0] != 2'b00) || (r_pc < c_PC_MIN) || (r_pc > c_PC_MAX);

    always_comb begin
        w_exc_valid = 1'b1;
        w_exc_code  = c_EXC_INT;
        if (w_pc_bad)                    w_exc_code = c_EXC_ADEL;
        else if (w_ri)                   w_exc_code = c_EXC_RI;
        else if (w_ov)                   w_exc_code = c_EXC_OV;
        else if (w_load && w_misalign)   w_exc_code = c_EXC_ADEL;
        else if (w_store && w_misalign)  w_exc_code = c_EXC_ADES;
        else                             w_exc_valid = 1'b0;
    end

    mips_cpu_cp0 u_cp0 (
        .clk             (clk),
        .reset           (reset),
        .i_interrupt     (interrupt),
        .i_pc            (r_pc),
        .i_in_delay_slot (r_in_ds),
        .i_exc_valid     (w_exc_valid),
        .i_exc_code      (w_exc_code),
        .i_mtc0          (w_mtc0),
        .i_cp0_addr      (w_rd),
        .i_wdata         (w_rt_val),
        .i_eret          (w_eret),
        .o_rdata         (w_cp0_rdata),
        .o_epc           (w_epc),
        .o_take          (w_take)
    );

    always_comb begin
        w_wb_data = w_alu_res;
        case (w_wb_sel)
            WB_MEM:  w_wb_data = w_load_val;
            WB_PC8:  w_wb_data = r_pc + 32'd8;
            WB_CP0:  w_wb_data = w_cp0_rdata;
            default: w_wb_data = w_alu_res;
        endcase
    end

    assign w_we = w_reg_write && (w_dst != 5'd0) && !w_take && !reset;

    assign bus.macroscopic_pc = r_pc;
    assign bus.i_inst_addr    = r_pc;
    assign bus.m_inst_addr    = r_pc;
    assign bus.w_inst_addr    = r_pc;
    assign bus.m_data_addr    = w_maddr;
    assign bus.m_data_wdata   = w_st_data;
    assign bus.m_data_byteen  = (w_store && !w_take && !reset) ? w_be : 4'b0000;
    assign bus.w_grf_we       = w_we;
    assign bus.w_grf_addr     = w_dst;
    assign bus.w_grf_wdata    = w_wb_data;

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_br_target = w_pc_plus4 + (w_imm_sext << 2);
    assign w_j_target  = {w_pc_plus4[31:28], w_inst[25:0], 2'b00};
    assign w_br_taken  = (w_beq && (w_rs_val == w_rt_val)) || (w_bne && (w_rs_val != w_rt_val));

    // NPC already holds the delay-slot address, so control transfers retarget NPC only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_npc   <= RESET_PC + 32'd4;
            r_in_ds <= 1'b0;
        end else if (w_take) begin
            r_pc    <= HANDLER_PC;
            r_npc   <= HANDLER_PC + 32'd4;
            r_in_ds <= 1'b0;
        end else if (w_eret) begin
            r_pc    <= w_epc;
            r_npc   <= w_epc + 32'd4;
            r_in_ds <= 1'b0;
        end else begin
            r_pc    <= r_npc;
            r_in_ds <= w_cti;
            if (w_jr)            r_npc <= w_rs_val;
            else if (w_jump)     r_npc <= w_j_target;
            else if (w_br_taken) r_npc <= w_br_target;
            else                 r_npc <= r_npc + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) r_grf[i] <= '0;
        end else if (w_we) begin
            r_grf[w_dst] <= w_wb_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_cpu
// Description : Directed self-checking bench for mips_cpu.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_cpu;

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic interrupt = 1'b0;
    int   checks    = 0;
    int   errors    = 0;

    logic [31:0] imem [0:4095];
    logic [31:0] dmem [0:1023] = '{default: '0};
    logic [31:0] w_ioff;

    mips_cpu_if bus ();

    mips_cpu #(
        .RESET_PC   (32'h0000_3000),
        .HANDLER_PC (32'h0000_4180)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .interrupt (interrupt),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    assign w_ioff           = bus.i_inst_addr - 32'h0000_3000;
    assign bus.i_inst_rdata = imem[w_ioff[13:2]];
    assign bus.m_data_rdata = dmem[bus.m_data_addr[11:2]];

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (bus.m_data_byteen[k])
                dmem[bus.m_data_addr[11:2]][8*k +: 8] <= bus.m_data_wdata[8*k +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] addr, input logic [31:0] word);
        logic [31:0] off;
        off = addr - 32'h0000_3000;
        imem[off[13:2]] = word;
    endtask

    // Blank memory is an undefined opcode; handler dumps Cause/EPC then erets
    task automatic load_base();
        for (int i = 0; i < 4096; i++) imem[i] = 32'hFC00_0000;
        put(32'h4180, 32'h401A_6800); // mfc0 $26,$13
        put(32'h4184, 32'h401B_7000); // mfc0 $27,$14
        put(32'h4188, 32'hAC00_7F20); // sw $0,0x7F20($0)
        put(32'h418C, 32'h4200_0018); // eret
    endtask

    task automatic release_reset(input string tag);
        @(negedge clk);
        #1;
        chk({tag, "_rst_pc"}, bus.i_inst_addr, 32'h3000);
        chk({tag, "_rst_we"}, {31'd0, bus.w_grf_we}, 32'd0);
        chk({tag, "_rst_be"}, {28'd0, bus.m_data_byteen}, 32'd0);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        // ---------------- ALU, byte store/load, overflow ----------------
        load_base();
        put(32'h3000, 32'h3401_1234); // ori  $1,$0,0x1234
        put(32'h3004, 32'h3402_00AB); // ori  $2,$0,0xAB
        put(32'h3008, 32'hA002_0002); // sb   $2,2($0)
        put(32'h300C, 32'h8003_0002); // lb   $3,2($0)
        put(32'h3010, 32'h3C04_7FFF); // lui  $4,0x7FFF
        put(32'h3014, 32'h3484_FFFF); // ori  $4,$4,0xFFFF
        put(32'h3018, 32'h2085_0001); // addi $5,$4,1
        release_reset("a");
        chk("ori_we",    {31'd0, bus.w_grf_we}, 32'd1);
        chk("ori_addr",  {27'd0, bus.w_grf_addr}, 32'd1);
        chk("ori_wdata", bus.w_grf_wdata, 32'h0000_1234);
        chk("ori_winst", bus.w_inst_addr, 32'h3000);
        step();
        step();
        chk("sb_be",    {28'd0, bus.m_data_byteen}, 32'b0100);
        chk("sb_wdata", bus.m_data_wdata, 32'hABAB_ABAB);
        chk("sb_addr",  bus.m_data_addr, 32'h2);
        step();
        chk("lb_wdata", bus.w_grf_wdata, 32'hFFFF_FFAB);
        chk("lb_addr",  {27'd0, bus.w_grf_addr}, 32'd3);
        step();
        step();
        chk("lui_ori",  bus.w_grf_wdata, 32'h7FFF_FFFF);
        step();
        chk("ov_we",    {31'd0, bus.w_grf_we}, 32'd0);
        step();
        chk("ov_pc",    bus.i_inst_addr, 32'h4180);
        chk("ov_cause", bus.w_grf_wdata, 32'h0000_0030);
        step();
        chk("ov_epc",   bus.w_grf_wdata, 32'h3018);

        // ---------------- interrupt during store, eret ----------------
        reset = 1'b1;
        #1;
        chk("async_rst_pc", bus.i_inst_addr, 32'h3000);
        load_base();
        put(32'h3000, 32'h3401_1001); // ori  $1,$0,0x1001
        put(32'h3004, 32'h4081_6000); // mtc0 $1,$12
        put(32'h3008, 32'h3402_0055); // ori  $2,$0,0x55
        put(32'h300C, 32'h3403_0010); // ori  $3,$0,0x10
        put(32'h3010, 32'hAC62_0000); // sw   $2,0($3)
        put(32'h3014, 32'h4004_6000); // mfc0 $4,$12
        put(32'h3018, 32'h3400_0005); // ori  $0,$0,5
        release_reset("b");
        step();
        step();
        step();
        step();
        interrupt = 1'b1;
        #1;
        chk("irq_sw_pc", bus.m_inst_addr, 32'h3010);
        chk("irq_sw_be", {28'd0, bus.m_data_byteen}, 32'd0);
        step();
        chk("irq_pc",    bus.i_inst_addr, 32'h4180);
        chk("irq_cause", bus.w_grf_wdata, 32'h0000_1000);
        step();
        chk("irq_epc",   bus.w_grf_wdata, 32'h3010);
        step();
        interrupt = 1'b0;
        #1;
        chk("hdl_sw_be",   {28'd0, bus.m_data_byteen}, 32'b1111);
        chk("hdl_sw_addr", bus.m_data_addr, 32'h7F20);
        step();
        step();
        chk("eret_pc",    bus.i_inst_addr, 32'h3010);
        chk("resw_be",    {28'd0, bus.m_data_byteen}, 32'b1111);
        chk("resw_addr",  bus.m_data_addr, 32'h10);
        chk("resw_wdata", bus.m_data_wdata, 32'h55);
        step();
        chk("sr_after_eret", bus.w_grf_wdata, 32'h0000_1001);
        step();
        chk("r0_we",      {31'd0, bus.w_grf_we}, 32'd0);

        // ---------------- branches, jal/jr, RI in delay slot ----------------
        reset = 1'b1;
        #1;
        load_base();
        put(32'h3000, 32'h1000_0002); // beq  $0,$0,+2
        put(32'h3004, 32'h3401_0007); // ori  $1,$0,7
        put(32'h3008, 32'h3401_0009); // ori  $1,$0,9 (skipped)
        put(32'h300C, 32'h0C00_0C08); // jal  0x3020
        put(32'h3010, 32'h3402_0001); // ori  $2,$0,1
        put(32'h3020, 32'h03E0_0008); // jr   $31
        release_reset("c");
        chk("beq_we",  {31'd0, bus.w_grf_we}, 32'd0);
        step();
        chk("ds_winst", bus.w_inst_addr, 32'h3004);
        chk("ds_wdata", bus.w_grf_wdata, 32'h7);
        step();
        chk("beq_tgt",   bus.i_inst_addr, 32'h300C);
        chk("jal_addr",  {27'd0, bus.w_grf_addr}, 32'd31);
        chk("jal_wdata", bus.w_grf_wdata, 32'h3014);
        step();
        chk("jal_ds",    bus.i_inst_addr, 32'h3010);
        step();
        chk("jal_tgt",   bus.i_inst_addr, 32'h3020);
        step();
        chk("ri_we",     {31'd0, bus.w_grf_we}, 32'd0);
        step();
        chk("ri_pc",     bus.i_inst_addr, 32'h4180);
        chk("ri_cause",  bus.w_grf_wdata, 32'h8000_0028);
        step();
        chk("ri_epc",    bus.w_grf_wdata, 32'h3020);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_cpu.md
MIPS_CPU -- requirements
Module: mips_cpu

Interface
REQ-001 The interface SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameters SHALL be: RESET_PC, 32'h0000_3000, PC after reset; HANDLER_PC, 32'h0000_4180, exception entry address.
REQ-003 Ports SHALL be as follows:
- clk in 1: rising-edge clock.
- reset in 1: asynchronous active-high reset.
- interrupt in 1: external interrupt request HWInt[2], level-sensitive.
- macroscopic_pc out 32: PC of the instruction currently executing.
- i_inst_addr out 32: fetch address, always equal to PC.
- i_inst_rdata in 32: instruction word, combinational.
- m_data_addr out 32: data byte address.
- m_data_rdata in 32: aligned read word, combinational.
- m_data_wdata out 32: store data, lane-replicated.
- m_data_byteen out 4: store byte enables; 0 means no store.
- m_inst_addr out 32: PC of the instruction driving the memory port.
- w_grf_we out 1: register-file write enable this cycle.
- w_grf_addr out 5: destination register.
- w_grf_wdata out 32: write-back value.
- w_inst_addr out 32: PC of the writing instruction.

Function
REQ-004 The CPU SHALL be single-cycle: one instruction commits per rising clk edge, and it SHALL have one architectural branch delay slot, implemented with PC and NPC registers.
REQ-005 The instruction set SHALL be: add, sub, and, or, slt, sltu, addi, addiu, andi, ori, lui, lw, lh, lb, sw, sh, sb, beq, bne, j, jal, jr, mfc0, mtc0, eret.
REQ-006 Immediates SHALL be sign-extended for addi, addiu, loads, stores and branches, and zero-extended for andi and ori; jal SHALL write PC+8 to $31.
REQ-007 Loads SHALL select the byte or half from m_data_rdata by m_data_addr[1:0] and sign-extend it.
REQ-008 Stores SHALL drive byteen as follows: sw 4'b1111; sh 4'b0011 or 4'b1100 by addr[1]; sb 4'b0001<<addr[1:0].
REQ-009 Store wdata SHALL be rt, {2{rt[15:0]}} or {4{rt[7:0]}} for sw, sh and sb respectively.
REQ-010 m_data_byteen SHALL be 0 for every non-store instruction.
REQ-011 Writes to $0 SHALL be discarded, and w_grf_we SHALL be 0 whenever w_grf_addr is 0.
REQ-012 m_inst_addr, w_inst_addr and macroscopic_pc SHALL all equal PC.
REQ-013 CP0 SHALL contain three registers:
- SR (reg 12): IM[15:10], EXL bit 1, IE bit 0.
- Cause (reg 13): BD bit 31, IP[15:10] as a live copy of HWInt, ExcCode[6:2].
- EPC (reg 14).
REQ-014 mtc0 SHALL write SR and EPC only; mfc0 SHALL read all three CP0 registers, and unimplemented CP0 registers SHALL read 0.
REQ-015 An interrupt SHALL be taken when interrupt=1, SR[12]=1, IE=1 and EXL=0; it SHALL take priority over any exception, with ExcCode 0.
REQ-016 The following exceptions SHALL be detected:
- RI (10): undefined opcode/funct.
- Ov (12): signed overflow on add, sub or addi.
- AdEL (4): misaligned PC or load, or PC outside 0x3000..0x6FFC.
- AdES (5): misaligned store.
REQ-017 When an interrupt or exception is taken, the current instruction SHALL be squashed: w_grf_we=0 and m_data_byteen=0 in that same cycle.
REQ-018 On the next edge after an interrupt or exception: EXL<=1; ExcCode is set; BD<=1 if the instruction is in a delay slot; EPC<=PC, or PC-4 when BD=1; PC<=HANDLER_PC; NPC<=HANDLER_PC+4.
REQ-019 eret SHALL set PC<=EPC, NPC<=EPC+4 and EXL<=0, and it SHALL have no delay slot.

Reset
REQ-020 While reset=1, and asynchronously on its assertion, the following SHALL be forced: PC=RESET_PC, NPC=RESET_PC+4, all GRF=0, SR=0, Cause=0, EPC=0.
REQ-021 During reset, w_grf_we=0 and m_data_byteen=0.

Structure
REQ-022 A shared package SHALL hold the opcode/funct constants, CP0 register numbers, ExcCode values, RESET_PC and HANDLER_PC.
REQ-023 The cp0 sub-module SHALL be separate and contain SR, Cause, EPC, interrupt request logic and exception entry/exit; decode, ALU and GRF stay in mips_cpu.

Verification
REQ-024 Reset release SHALL give i_inst_addr=0x3000; "ori $1,$0,0x1234" SHALL give w_grf_we=1, addr=1, wdata=0x00001234, w_inst_addr=0x3000.
REQ-025 "sb" of rt=0x000000AB at address 0x2 SHALL give byteen=4'b0100 and wdata=0xABABABAB; a following "lb" from address 0x2 SHALL give 0xFFFFFFAB.
REQ-026 "beq $0,$0,+2" at 0x3000 SHALL execute the delay slot at 0x3004, and the next PC SHALL be 0x300C.
REQ-027 With SR=0x00001001, raising interrupt during an "sw" at 0x3010 SHALL give byteen=0 that cycle, then PC=0x4180, EPC=0x3010 and Cause[6:2]=0.
REQ-028 A handler ending with "sw" to 0x7F20 then eret SHALL return to PC=0x3010 with EXL=0 and re-execute the store.
REQ-029 addi of 0x7FFFFFFF+1 SHALL produce no GRF write, ExcCode=12 and PC=0x4180.
